// File: rtl/uart_rx_if.sv
// Output-side bundle of the UART receiver: byte valid/ready handshake plus error pulses.
interface uart_rx_if;
  logic       urx_valid;
  logic [7:0] urx_data;
  logic       urx_ready;
  logic       urx_frame_err;
  logic       urx_overrun;
  logic       urx_parity_err;

  modport master (
    output urx_valid,
    output urx_data,
    output urx_frame_err,
    output urx_overrun,
    output urx_parity_err,
    input  urx_ready
  );

  modport slave (
    input  urx_valid,
    input  urx_data,
    input  urx_frame_err,
    input  urx_overrun,
    input  urx_parity_err,
    output urx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready output register.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx #(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      urx_pin,
  uart_rx_if.master bus
);

  localparam int unsigned B  = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned H  = B / 2;
  localparam int unsigned TW = $clog2(B);
  localparam logic [TW-1:0] LOAD_HALF = TW'(H - 1);
  localparam logic [TW-1:0] LOAD_FULL = TW'(B - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          parity_err_q, parity_err_d;
`endif
  logic          s;
  logic          timer_zero;
  logic          deliver;

  assign s          = sync_q[1];
  assign timer_zero = (timer_q == '0);

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], urx_pin};
    timer_d     = timer_zero ? timer_q : timer_q - TW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    valid_d     = valid_q;
    data_d      = data_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    if (valid_q && bus.urx_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!s) begin
          state_d = S_START;
          timer_d = LOAD_HALF;
        end
      end
      S_START: begin
        // A start bit that is gone by mid-bit was line noise.
        if (timer_zero) begin
          if (s) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            timer_d   = LOAD_FULL;
            bit_idx_d = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (timer_zero) begin
          shift_d   = {s, shift_q[7:1]};
          timer_d   = LOAD_FULL;
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (timer_zero) begin
          par_bad_d = s ^ (^shift_q);
          timer_d   = LOAD_FULL;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (timer_zero) begin
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
          deliver      = s && !par_bad_q;
`else
          deliver      = s;
`endif
          if (s) begin
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A simultaneous handshake frees the register for the new byte.
    if (deliver) begin
      if (valid_q && !bus.urx_ready) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      timer_q     <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      valid_q     <= 1'b0;
      data_q      <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.urx_valid     = valid_q;
  assign bus.urx_data      = data_q;
  assign bus.urx_frame_err = frame_err_q;
  assign bus.urx_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.urx_parity_err = parity_err_q;
`else
  assign bus.urx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with B = 10, H = 5.
module tb_uart_rx;

  localparam int unsigned CF = 1_000_000;
  localparam int unsigned BR = 100_000;
  localparam int B = 10;
`ifdef UART_RX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  // Cycles from the first low drive until urx_valid is visible: 2 + H + (FB-1)*B + 1.
  localparam int DLY = 2 + 5 + (FB - 1) * B + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic urx_pin;

  uart_rx_if bus();

  uart_rx #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .urx_pin (urx_pin),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_t0 = 0;

  int n_valid_cyc = 0;
  int n_accept = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_perr = 0;
  int rise_cyc = -1;
  logic [7:0] last_acc = 8'h00;
  logic valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle.
  always @(negedge clk) begin
    if (bus.urx_valid === 1'b1) n_valid_cyc++;
    if (bus.urx_valid === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
    if (bus.urx_valid === 1'b1 && bus.urx_ready === 1'b1) begin
      n_accept++;
      last_acc = bus.urx_data;
    end
    if (bus.urx_frame_err === 1'b1) n_ferr++;
    if (bus.urx_overrun === 1'b1) n_ovr++;
    if (bus.urx_parity_err === 1'b1) n_perr++;
    valid_prev = bus.urx_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    urx_pin = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one frame, optionally pulsing urx_ready for one cycle at tick rdy_at.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_v,
                            input int stop_len, input int rdy_at);
    int total;
    int idx;
    logic bitv;
    total = (FB - 1) * B + stop_len;
    frame_t0 = cyc;
    for (int t = 0; t < total; t++) begin
      idx = t / B;
      if (idx == 0) bitv = 1'b0;
      else if (idx <= 8) bitv = d[3'(idx - 1)];
      else if (idx == 9 && FB == 11) bitv = par;
      else bitv = stop_v;
      urx_pin = bitv;
      if (rdy_at >= 0 && t == rdy_at) bus.urx_ready = 1'b1;
      if (rdy_at >= 0 && t == rdy_at + 1) bus.urx_ready = 1'b0;
      tick();
    end
    urx_pin = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    urx_pin = 1'b1;
    bus.urx_ready = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus.urx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.urx_valid); end
    checks++;
    if (bus.urx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.urx_data); end
    checks++;
    if (bus.urx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.urx_frame_err); end
    checks++;
    if (bus.urx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.urx_overrun); end
    checks++;
    if (bus.urx_parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", bus.urx_parity_err); end
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_basic();
    int v0, a0, f0, o0, p0;
    v0 = n_valid_cyc; a0 = n_accept; f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
    bus.urx_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b1, B, -1);
    idle(5);
    checks++;
    if (rise_cyc - frame_t0 !== DLY) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", rise_cyc - frame_t0, DLY); end
    checks++;
    if (n_valid_cyc - v0 !== 1) begin errors++; $display("FAIL basic_valid_width: got %0d expected 1", n_valid_cyc - v0); end
    checks++;
    if (n_accept - a0 !== 1 || last_acc !== 8'hA5) begin errors++; $display("FAIL basic_data: got %0d bytes last %h expected 1 byte A5", n_accept - a0, last_acc); end
    checks++;
    if (n_ferr - f0 + n_ovr - o0 + n_perr - p0 !== 0) begin errors++; $display("FAIL basic_no_err: got %0d pulses expected 0", n_ferr - f0 + n_ovr - o0 + n_perr - p0); end
  endtask

  task automatic test_back_to_back();
    int a0, o0, f0;
    a0 = n_accept; o0 = n_ovr; f0 = n_ferr;
    bus.urx_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, B, -1);
    send_frame(8'hC3, 1'b0, 1'b1, B, -1);
    idle(5);
    checks++;
    if (bus.urx_valid !== 1'b1 || bus.urx_data !== 8'h3C) begin errors++; $display("FAIL b2b_hold: got valid %b data %h expected 1 3C", bus.urx_valid, bus.urx_data); end
    checks++;
    if (n_ovr - o0 !== 1) begin errors++; $display("FAIL b2b_overrun: got %0d pulses expected 1", n_ovr - o0); end
    checks++;
    if (n_accept - a0 !== 0 || n_ferr - f0 !== 0) begin errors++; $display("FAIL b2b_quiet: got %0d accepts %0d ferr expected 0 0", n_accept - a0, n_ferr - f0); end
  endtask

  task automatic test_simultaneous();
    int a0, o0;
    a0 = n_accept; o0 = n_ovr;
    send_frame(8'hC3, 1'b0, 1'b1, B, DLY - 1);
    idle(3);
    checks++;
    if (bus.urx_valid !== 1'b1 || bus.urx_data !== 8'hC3) begin errors++; $display("FAIL simul_load: got valid %b data %h expected 1 C3", bus.urx_valid, bus.urx_data); end
    checks++;
    if (n_ovr - o0 !== 0) begin errors++; $display("FAIL simul_overrun: got %0d pulses expected 0", n_ovr - o0); end
    checks++;
    if (n_accept - a0 !== 1 || last_acc !== 8'h3C) begin errors++; $display("FAIL simul_consume: got %0d accepts last %h expected 1 3C", n_accept - a0, last_acc); end
    bus.urx_ready = 1'b1;
    tick();
    bus.urx_ready = 1'b0;
    checks++;
    if (bus.urx_valid !== 1'b0 || last_acc !== 8'hC3) begin errors++; $display("FAIL simul_drain: got valid %b last %h expected 0 C3", bus.urx_valid, last_acc); end
  endtask

  task automatic test_frame_error();
    int a0, f0, o0;
    a0 = n_accept; f0 = n_ferr; o0 = n_ovr;
    bus.urx_ready = 1'b1;
    send_frame(8'h55, 1'b0, 1'b0, 3 * B, -1);
    idle(2 * B);
    checks++;
    if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles expected 1", n_ferr - f0); end
    checks++;
    if (n_accept - a0 !== 0) begin errors++; $display("FAIL ferr_dropped: got %0d bytes expected 0", n_accept - a0); end
    send_frame(8'h12, 1'b0, 1'b1, B, -1);
    idle(5);
    checks++;
    if (n_accept - a0 !== 1 || last_acc !== 8'h12) begin errors++; $display("FAIL ferr_recover: got %0d bytes last %h expected 1 12", n_accept - a0, last_acc); end
    checks++;
    if (n_ferr - f0 !== 1 || n_ovr - o0 !== 0) begin errors++; $display("FAIL ferr_extra: got ferr %0d ovr %0d expected 1 0", n_ferr - f0, n_ovr - o0); end
  endtask

  task automatic test_glitch();
    int v0, f0, a0;
    v0 = n_valid_cyc; f0 = n_ferr; a0 = n_accept;
    bus.urx_ready = 1'b1;
    urx_pin = 1'b0;
    tick(); tick(); tick();
    idle(3 * B);
    checks++;
    if (n_valid_cyc - v0 !== 0 || n_ferr - f0 !== 0) begin errors++; $display("FAIL glitch_ignored: got valid %0d ferr %0d expected 0 0", n_valid_cyc - v0, n_ferr - f0); end
    send_frame(8'h5A, 1'b0, 1'b1, B, -1);
    idle(5);
    checks++;
    if (n_accept - a0 !== 1 || last_acc !== 8'h5A) begin errors++; $display("FAIL glitch_recover: got %0d bytes last %h expected 1 5A", n_accept - a0, last_acc); end
  endtask

  task automatic test_reset_mid_frame();
    int a0;
    bus.urx_ready = 1'b0;
    send_frame(8'h81, 1'b0, 1'b1, B, -1);
    idle(5);
    checks++;
    if (bus.urx_valid !== 1'b1 || bus.urx_data !== 8'h81) begin errors++; $display("FAIL rst_pre: got valid %b data %h expected 1 81", bus.urx_valid, bus.urx_data); end
    urx_pin = 1'b0;
    for (int i = 0; i < 5 * B + 5; i++) tick();
    rst_n = 1'b0;
    urx_pin = 1'b1;
    tick();
    checks++;
    if (bus.urx_valid !== 1'b0 || bus.urx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_out: got valid %b data %h expected 0 00", bus.urx_valid, bus.urx_data); end
    checks++;
    if ({bus.urx_frame_err, bus.urx_overrun, bus.urx_parity_err} !== 3'b000) begin errors++; $display("FAIL rst_mid_err: got %b expected 000", {bus.urx_frame_err, bus.urx_overrun, bus.urx_parity_err}); end
    rst_n = 1'b1;
    idle(2 * B);
    a0 = n_accept;
    bus.urx_ready = 1'b1;
    send_frame(8'hFF, 1'b0, 1'b1, B, -1);
    idle(5);
    checks++;
    if (n_accept - a0 !== 1 || last_acc !== 8'hFF) begin errors++; $display("FAIL rst_mid_next: got %0d bytes last %h expected 1 FF", n_accept - a0, last_acc); end
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int a0, p0;
    a0 = n_accept; p0 = n_perr;
    bus.urx_ready = 1'b1;
    send_frame(8'h07, 1'b1, 1'b1, B, -1);
    idle(5);
    checks++;
    if (n_accept - a0 !== 1 || last_acc !== 8'h07 || n_perr - p0 !== 0) begin errors++; $display("FAIL parity_good: got %0d bytes last %h perr %0d expected 1 07 0", n_accept - a0, last_acc, n_perr - p0); end
    a0 = n_accept;
    send_frame(8'h07, 1'b0, 1'b1, B, -1);
    idle(5);
    checks++;
    if (n_perr - p0 !== 1) begin errors++; $display("FAIL parity_bad_pulse: got %0d cycles expected 1", n_perr - p0); end
    checks++;
    if (n_accept - a0 !== 0) begin errors++; $display("FAIL parity_bad_drop: got %0d bytes expected 0", n_accept - a0); end
`else
    checks++;
    if (n_perr !== 0 || bus.urx_parity_err !== 1'b0) begin errors++; $display("FAIL parity_tied: got %0d pulses expected 0", n_perr); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_simultaneous();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-oriented UART receiver. It recovers 8N1 frames (optionally 8E1) from the asynchronous `urx_pin`, samples each bit at mid-bit using a clock-cycle bit timer, and presents each byte on a one-entry valid/ready output register. It is the receive half of the UART path in the board-level demos, sits directly behind the `UART_RX` pin, and feeds user logic such as an echo or command parser.

## Interface
- `CLOCK_FREQ`, 100_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 115_200, line bit rate.
- Derived, not overridable: `B = CLOCK_FREQ / BAUD_RATE` (integer division, must be ≥ 4) and `H = B / 2`.

Ports:
- `clk` input 1: single system clock; all logic is rising-edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `urx_pin` input 1: raw serial line; idles high; asynchronous to `clk`.
- `urx_valid` output 1: a byte is held in the output register.
- `urx_data` output 8: received byte, LSB first on the wire.
- `urx_ready` input 1: consumer accepts the byte when `urx_valid && urx_ready`.
- `urx_frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `urx_overrun` output 1: one-cycle pulse when a completed byte is dropped because the output register is full.
- `urx_parity_err` output 1: one-cycle pulse on a parity mismatch; tied 0 when `UART_RX_PARITY_EN` is not defined.

## Operation
- **Input synchronizer:** `urx_pin` passes through a 2-flop synchronizer. Both flops reset to 1. All FSM decisions use the synchronized value `s`.
- **Bit timer:** a down-counter sized `$clog2(B)`, reloaded on each state entry. The FSM has these states:
  - **IDLE:** when `s == 0`, load the timer with `H-1` and go to START.
  - **START:** when the timer hits 0, sample `s`.
    - If `s == 1`, it was a glitch: return to IDLE.
    - Otherwise load `B-1`, clear the bit index, and go to DATA.
  - **DATA:** at each timer 0, shift `s` into the MSB of the shift register (LSB-first reception) and reload `B-1`. After bit index 7, go to PARITY if enabled, else STOP.
  - **PARITY:** at timer 0, compare `s` with the XOR of the 8 data bits (even parity), then go to STOP.
  - **STOP:** at timer 0, sample `s`.
    - If `s == 1`, the frame is good: deliver the byte and go to IDLE.
    - If `s == 0`, pulse `urx_frame_err`, drop the byte, and go to BREAK.
  - **BREAK:** wait until `s == 1`, then go to IDLE. No start is detected while the line is held low.
- **Parity error:** a mismatch pulses `urx_parity_err` in the STOP-sample cycle and drops the byte, even if the stop bit is good.
- **Output register:** one entry.
  - Delivery loads `urx_data` and sets `urx_valid`.
  - `urx_valid` is cleared on a handshake and stays high with `urx_data` stable until then.
- **Full register:** if delivery occurs while `urx_valid && !urx_ready`, pulse `urx_overrun`, keep the old byte, and discard the new one.
- **Simultaneous handshake and delivery:** the old byte is consumed, the new byte is loaded, `urx_valid` stays 1, and no overrun is flagged.
- **Reset mid-frame:** aborts the frame immediately. The receiver returns to IDLE and the partial byte is lost.

## Timing
- **Reset values:**
  - `urx_valid = 0`, `urx_data = 8'h00`.
  - `urx_frame_err`, `urx_overrun` and `urx_parity_err` are all 0.
  - FSM in IDLE, synchronizer flops 1.
- **Latency:** let cycle 0 be the first `clk` edge that registers `urx_pin == 0` into sync flop 1.
  - START sample occurs at cycle `2 + H`.
  - Data bit k is sampled at cycle `2 + H + (k+1)·B`.
  - STOP is sampled at cycle `2 + H + 9·B`, plus `B` with parity.
  - `urx_valid` is high from the cycle after the STOP sample.
- **Pulse timing:** error pulses are exactly one cycle wide and are registered; they are high in the same cycle `urx_valid` would have risen.
- **Back-to-back frames:** a new start bit is accepted immediately after the STOP sample, so frames with a single stop bit are received without loss.
- **Baud tolerance:** mid-bit sampling tolerates cumulative clock mismatch up to ±H cycles by the stop bit.

## Configuration
- **`UART_RX_PARITY_EN`**
  - **Defined:** the PARITY state is compiled in and frames are 8E1 (11 bits). Parity is checked and `urx_parity_err` is live.
  - **Not defined:** the PARITY state and its logic are absent, frames are 8N1 (10 bits), and `urx_parity_err` is constant 0.

## Test plan
Bench parameters: `CLOCK_FREQ = 1_000_000`, `BAUD_RATE = 100_000`, giving `B = 10`, `H = 5`.

1. **Basic reception:** reset, then drive byte `8'hA5` 8N1 with `urx_ready` = 1 → `urx_valid` pulses for one cycle with `urx_data = 8'hA5` at cycle 2+5+90+1 after the start edge; no error pulses.
2. **Back-to-back with stalled consumer:** send `8'h3C` then `8'hC3`, holding `urx_ready = 0` until after the second frame → `urx_data` stays `8'h3C` with `urx_valid` = 1, and `urx_overrun` pulses once at the second delivery.
3. **Simultaneous handshake:** assert `urx_ready` exactly in the cycle the second byte is delivered → `urx_data` becomes `8'hC3`, `urx_valid` stays 1, and `urx_overrun` stays 0.
4. **Framing error:** send `8'h55` with the stop bit low for 3·B cycles, then idle high, then send `8'h12` → `urx_frame_err` pulses once, no byte is delivered for `8'h55`, and `8'h12` is received correctly.
5. **Glitch and reset:**
   - A low pulse of 3 cycles on an idle line → nothing is delivered and the FSM returns to IDLE.
   - Asserting `rst_n = 0` during data bit 4 of a frame → all outputs read their reset values, and the next full frame `8'hFF` is received.
6. **Parity (with `UART_RX_PARITY_EN`):**
   - `8'h07` with parity bit 1 → delivered.
   - `8'h07` with parity bit 0 → `urx_parity_err` pulses once and nothing is delivered.
